// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types and default parameters for the memory responder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    localparam int DEF_DEPTH   = 64;
    localparam int DEF_AW      = 6;
    localparam int DEF_LATENCY = 0;
    localparam int LAT_W       = 4;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// mem_array : DEPTH x 32 storage, byte-enable write, registered read, no reset
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;
    logic [31:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : valid/ready memory responder with configurable wait states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int AW      = DEF_AW,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [LAT_W-1:0] LAT_INIT =
        (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    mem_state_t       state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             we_q, we_d;
    logic             err_q, err_d;

    logic             accept;
    logic             req_err;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [31:0]      arr_rdata;

    // Range check on the full address so out-of-range never aliases a real word.
    assign req_err   = (req_addr >= 32'(DEPTH));
    assign req_ready = rst_n & (state_q == IDLE);
    assign accept    = req_valid & req_ready;
    assign rd_addr   = (state_q == IDLE) ? req_addr[AW-1:0] : addr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr[AW-1:0];
                    we_d   = req_we;
                    err_d  = req_err;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_INIT;
                    end else begin
                        state_d = RESP;
                        rd_en   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    rd_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (accept & req_we & ~req_err),
        .wr_addr (req_addr[AW-1:0]),
        .wr_data (req_wdata),
        .wr_strb (req_wstrb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (arr_rdata)
    );

    // Read data is only exposed for in-range reads while a response is up.
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? arr_rdata : 32'h0;

endmodule

`default_nettype wire
